// File: rtl/bus_control_sequencer.sv
// bus_control_sequencer: control-side master for the shared 8-bit accumulator bus.
// Accepts 4-bit opcodes over op_valid/op_ready and sequences the bus-enable and
// register-load strobes; every output is registered, with no combinational path from op.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   op[3:0], op_valid   opcode handshake input; op_ready is high only in IDLE
//   alu_cf, alu_zf      ALU carry / zero (sampled only when SEQ_FLAGS_EN is defined)
//   in_en, Ea, Eb, Eu   bus driver enables (at most one is high at a time)
//   nLa, nLb            active-low A / B register loads
//   sub                 ALU subtract select (held through ADD/SUB setup cycles)
//   out_ld              output latch capture
//   done, illegal       one-cycle pulses; halted is high in HALT
//   icount[7:0]         retired-instruction counter (wraps)
//   flag_c, flag_z      latched ALU flags
//
// Parameters:
//   SETTLE    ADD/SUB setup cycles before Eu is asserted (0..3)
//   HALT_ILL  1: an illegal opcode enters HALT; 0: it executes as a NOP
//
// Build option: define SEQ_FLAGS_EN to latch the ALU flags and make opcode 8
// a conditional subtract (SUBC). Without it the flags are constant 0 and
// opcode 8 is illegal.
module bus_control_sequencer #(
    parameter int SETTLE   = 1,
    parameter bit HALT_ILL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] op,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic       alu_cf,
    input  logic       alu_zf,
    output logic       in_en,
    output logic       Ea,
    output logic       Eb,
    output logic       Eu,
    output logic       nLa,
    output logic       nLb,
    output logic       sub,
    output logic       out_ld,
    output logic       done,
    output logic       illegal,
    output logic       halted,
    output logic [7:0] icount,
    output logic       flag_c,
    output logic       flag_z
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDA  = 4'd1;
    localparam logic [3:0] OP_LDB  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_OUTA = 4'd5;
    localparam logic [3:0] OP_OUTB = 4'd6;
    localparam logic [3:0] OP_HLT  = 4'd7;
`ifdef SEQ_FLAGS_EN
    localparam logic [3:0] OP_SUBC = 4'd8;
`endif

    // The counter starts at SETTLE-1 so that SETUP lasts exactly SETTLE cycles.
    localparam logic [1:0] LP_CNT_INIT =
        (SETTLE > 0) ? 2'(SETTLE - 1) : 2'd0;

    state_t     r_state;
    logic [1:0] r_cnt;
    logic [3:0] r_op;
    logic       r_op_ready;
    logic       r_in_en;
    logic       r_ea;
    logic       r_eb;
    logic       r_eu;
    logic       r_nla;
    logic       r_nlb;
    logic       r_sub;
    logic       r_out_ld;
    logic       r_done;
    logic       r_illegal;
    logic       r_halted;
    logic [7:0] r_icount;

    state_t     w_state_nxt;
    logic [1:0] w_cnt_nxt;
    logic [3:0] w_op_nxt;
    logic       w_accept;
    logic [3:0] w_dec_op;
    logic       w_dec_ill;
    logic       w_is_alu;
    logic       w_fire;
    logic [3:0] w_fire_op;
    logic       w_setup_sub;
    logic       w_done_nxt;
    logic       w_ill_nxt;
    logic       w_halt_nxt;
    logic       w_in_en_nxt;
    logic       w_ea_nxt;
    logic       w_eb_nxt;
    logic       w_eu_nxt;
    logic       w_nla_nxt;
    logic       w_nlb_nxt;
    logic       w_sub_nxt;
    logic       w_out_ld_nxt;

`ifdef SEQ_FLAGS_EN
    logic r_flag_c;
    logic r_flag_z;
`endif

    assign w_accept = op_valid & r_op_ready;

    // Opcode decode: illegal opcodes are rewritten to NOP and flagged;
    // SUBC resolves to SUB or NOP against the current carry flag.
    always_comb begin
        w_dec_op  = op;
        w_dec_ill = 1'b0;
`ifdef SEQ_FLAGS_EN
        if (op == OP_SUBC) begin
            w_dec_op = r_flag_c ? OP_SUB : OP_NOP;
        end else if (op[3]) begin
            w_dec_op  = OP_NOP;
            w_dec_ill = 1'b1;
        end
`else
        if (op[3]) begin
            w_dec_op  = OP_NOP;
            w_dec_ill = 1'b1;
        end
`endif
    end

    assign w_is_alu = (w_dec_op == OP_ADD) || (w_dec_op == OP_SUB);

    // Next-state logic. w_fire marks the transition into EXEC; the strobes
    // for w_fire_op are then registered so that they appear during EXEC.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_fire      = 1'b0;
        w_fire_op   = r_op;
        w_setup_sub = 1'b0;
        w_done_nxt  = 1'b0;
        w_ill_nxt   = 1'b0;
        w_halt_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_op_nxt = w_dec_op;
                    if (w_dec_ill && HALT_ILL) begin
                        w_state_nxt = S_HALT;
                        w_ill_nxt   = 1'b1;
                        w_halt_nxt  = 1'b1;
                    end else if (w_dec_op == OP_HLT) begin
                        w_state_nxt = S_HALT;
                        w_done_nxt  = 1'b1;
                        w_halt_nxt  = 1'b1;
                    end else if (w_is_alu && (SETTLE > 0)) begin
                        w_state_nxt = S_SETUP;
                        w_cnt_nxt   = LP_CNT_INIT;
                        w_setup_sub = (w_dec_op == OP_SUB);
                    end else begin
                        w_state_nxt = S_EXEC;
                        w_fire      = 1'b1;
                        w_fire_op   = w_dec_op;
                        w_done_nxt  = 1'b1;
                        w_ill_nxt   = w_dec_ill;
                    end
                end
            end
            S_SETUP: begin
                if (r_cnt == 2'd0) begin
                    w_state_nxt = S_EXEC;
                    w_fire      = 1'b1;
                    w_fire_op   = r_op;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - 2'd1;
                    w_setup_sub = (r_op == OP_SUB);
                end
            end
            S_EXEC: begin
                w_state_nxt = S_IDLE;
            end
            S_HALT: begin
                w_halt_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // EXEC strobe decode; sub may also be held from a pending SUB setup.
    always_comb begin
        w_in_en_nxt  = 1'b0;
        w_ea_nxt     = 1'b0;
        w_eb_nxt     = 1'b0;
        w_eu_nxt     = 1'b0;
        w_nla_nxt    = 1'b1;
        w_nlb_nxt    = 1'b1;
        w_sub_nxt    = w_setup_sub;
        w_out_ld_nxt = 1'b0;
        if (w_fire) begin
            case (w_fire_op)
                OP_LDA: begin
                    w_in_en_nxt = 1'b1;
                    w_nla_nxt   = 1'b0;
                end
                OP_LDB: begin
                    w_in_en_nxt = 1'b1;
                    w_nlb_nxt   = 1'b0;
                end
                OP_ADD: begin
                    w_eu_nxt  = 1'b1;
                    w_nla_nxt = 1'b0;
                end
                OP_SUB: begin
                    w_eu_nxt  = 1'b1;
                    w_nla_nxt = 1'b0;
                    w_sub_nxt = 1'b1;
                end
                OP_OUTA: begin
                    w_ea_nxt     = 1'b1;
                    w_out_ld_nxt = 1'b1;
                end
                OP_OUTB: begin
                    w_eb_nxt     = 1'b1;
                    w_out_ld_nxt = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 2'd0;
            r_op       <= OP_NOP;
            r_op_ready <= 1'b1;
            r_in_en    <= 1'b0;
            r_ea       <= 1'b0;
            r_eb       <= 1'b0;
            r_eu       <= 1'b0;
            r_nla      <= 1'b1;
            r_nlb      <= 1'b1;
            r_sub      <= 1'b0;
            r_out_ld   <= 1'b0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
            r_halted   <= 1'b0;
            r_icount   <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_op       <= w_op_nxt;
            r_op_ready <= (w_state_nxt == S_IDLE);
            r_in_en    <= w_in_en_nxt;
            r_ea       <= w_ea_nxt;
            r_eb       <= w_eb_nxt;
            r_eu       <= w_eu_nxt;
            r_nla      <= w_nla_nxt;
            r_nlb      <= w_nlb_nxt;
            r_sub      <= w_sub_nxt;
            r_out_ld   <= w_out_ld_nxt;
            r_done     <= w_done_nxt;
            r_illegal  <= w_ill_nxt;
            r_halted   <= w_halt_nxt;
            // Retire on the edge that closes the done cycle.
            r_icount   <= r_icount + {7'd0, r_done};
        end
    end

`ifdef SEQ_FLAGS_EN
    // Eu is high only in an ADD/SUB EXEC cycle, so it marks when to sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
        end else if (r_eu) begin
            r_flag_c <= alu_cf;
            r_flag_z <= alu_zf;
        end
    end

    assign flag_c = r_flag_c;
    assign flag_z = r_flag_z;
`else
    logic w_unused_flags;
    assign w_unused_flags = alu_cf ^ alu_zf;
    assign flag_c = 1'b0;
    assign flag_z = 1'b0;
`endif

    assign op_ready = r_op_ready;
    assign in_en    = r_in_en;
    assign Ea       = r_ea;
    assign Eb       = r_eb;
    assign Eu       = r_eu;
    assign nLa      = r_nla;
    assign nLb      = r_nlb;
    assign sub      = r_sub;
    assign out_ld   = r_out_ld;
    assign done     = r_done;
    assign illegal  = r_illegal;
    assign halted   = r_halted;
    assign icount   = r_icount;

endmodule

// File: tb/tb_bus_control_sequencer.sv
// tb_bus_control_sequencer: directed bench for bus_control_sequencer (SETTLE=2).
// Strobe vector order: {in_en,Ea,Eb,Eu,nLa,nLb,sub,out_ld,done}.
module tb_bus_control_sequencer;

    localparam logic [8:0] IDLE_V = 9'b000011000;

    logic       clk;
    logic       rst;
    logic [3:0] op;
    logic       op_valid;
    logic       op_ready;
    logic       alu_cf;
    logic       alu_zf;
    logic       in_en;
    logic       Ea;
    logic       Eb;
    logic       Eu;
    logic       nLa;
    logic       nLb;
    logic       sub;
    logic       out_ld;
    logic       done;
    logic       illegal;
    logic       halted;
    logic [7:0] icount;
    logic       flag_c;
    logic       flag_z;
    logic [8:0] strb;

    int errors = 0;
    int checks = 0;

    assign strb = {in_en, Ea, Eb, Eu, nLa, nLb, sub, out_ld, done};

    bus_control_sequencer #(
        .SETTLE  (2),
        .HALT_ILL(1'b0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .op      (op),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .alu_cf  (alu_cf),
        .alu_zf  (alu_zf),
        .in_en   (in_en),
        .Ea      (Ea),
        .Eb      (Eb),
        .Eu      (Eu),
        .nLa     (nLa),
        .nLb     (nLb),
        .sub     (sub),
        .out_ld  (out_ld),
        .done    (done),
        .illegal (illegal),
        .halted  (halted),
        .icount  (icount),
        .flag_c  (flag_c),
        .flag_z  (flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] o);
        op       = o;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        op       = 4'd0;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        op_valid = 1'b0;
        op       = 4'd0;
        alu_cf   = 1'b0;
        alu_zf   = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        op_valid = 1'b0;
        op       = 4'd0;
        alu_cf   = 1'b0;
        alu_zf   = 1'b0;
        #1;
        checks++;
        if (strb !== IDLE_V || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_strobes: got %b/%b want %b/1", strb, op_ready, IDLE_V);
        end
        checks++;
        if ({illegal, halted, flag_c, flag_z} !== 4'b0000 || icount !== 8'd0) begin
            errors++;
            $display("FAIL reset_status: got %b icount=%0d want 0000 icount=0",
                     {illegal, halted, flag_c, flag_z}, icount);
        end
        tick();
        rst = 1'b0;
        tick();
        send(4'd1);
        tick();
        send(4'd4);
        checks++;
        if ({sub, op_ready} !== 2'b10) begin
            errors++;
            $display("FAIL reset_pre_setup: got sub,rdy=%b want 10", {sub, op_ready});
        end
        rst = 1'b1;
        #1;
        checks++;
        if (strb !== IDLE_V || op_ready !== 1'b1 || icount !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_setup: got %b rdy=%b icount=%0d want %b 1 0",
                     strb, op_ready, icount, IDLE_V);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lda;
        do_reset();
        send(4'd1);
        checks++;
        if (strb !== 9'b100001001 || op_ready !== 1'b0) begin
            errors++;
            $display("FAIL lda_exec: got %b rdy=%b want 100001001 0", strb, op_ready);
        end
        tick();
        checks++;
        if (strb !== IDLE_V || op_ready !== 1'b1 || icount !== 8'd1) begin
            errors++;
            $display("FAIL lda_after: got %b rdy=%b icount=%0d want %b 1 1",
                     strb, op_ready, icount, IDLE_V);
        end
    endtask

    task automatic test_sub_settle;
        logic [8:0] exp_v [0:3];
        exp_v[0] = 9'b000011100;
        exp_v[1] = 9'b000011100;
        exp_v[2] = 9'b000101101;
        exp_v[3] = IDLE_V;
        do_reset();
        send(4'd4);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (strb !== exp_v[k]) begin
                errors++;
                $display("FAIL sub_cycle%0d: got %b want %b", k + 1, strb, exp_v[k]);
            end
            if (k < 3) tick();
        end
        checks++;
        if (icount !== 8'd1) begin
            errors++;
            $display("FAIL sub_icount: got %0d want 1", icount);
        end
    endtask

    task automatic test_stream;
        logic [3:0] ops   [0:9];
        logic [8:0] exp_v [0:9];
        ops   = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
        exp_v = '{9'b100001001, IDLE_V, 9'b100010001, IDLE_V, IDLE_V,
                  IDLE_V, 9'b000101001, IDLE_V, 9'b010011011, IDLE_V};
        do_reset();
        for (int k = 0; k < 10; k++) begin
            op       = ops[k];
            op_valid = (k < 9);
            tick();
            checks++;
            if (strb !== exp_v[k]) begin
                errors++;
                $display("FAIL stream_c%0d: got %b want %b", k + 1, strb, exp_v[k]);
            end
            checks++;
            if ($countones({in_en, Ea, Eb, Eu}) > 1 || (nLa === 1'b0 && nLb === 1'b0)) begin
                errors++;
                $display("FAIL stream_excl_c%0d: got %b want <=1 driver, one load", k + 1, strb);
            end
        end
        op_valid = 1'b0;
        checks++;
        if (icount !== 8'd4) begin
            errors++;
            $display("FAIL stream_icount: got %0d want 4", icount);
        end
    endtask

    task automatic test_illegal;
        do_reset();
        send(4'hB);
        checks++;
        if (illegal !== 1'b1 || strb[8:1] !== IDLE_V[8:1]) begin
            errors++;
            $display("FAIL illegal_B: got ill=%b strb=%b want 1 %b", illegal, strb, IDLE_V);
        end
        tick();
        checks++;
        if (illegal !== 1'b0 || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_pulse: got ill=%b rdy=%b want 0 1", illegal, op_ready);
        end
`ifndef SEQ_FLAGS_EN
        send(4'h8);
        checks++;
        if (illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_8: got %b want 1", illegal);
        end
        tick();
`endif
    endtask

    task automatic test_halt;
        do_reset();
        send(4'd7);
        checks++;
        if ({halted, op_ready, done} !== 3'b101) begin
            errors++;
            $display("FAIL hlt_entry: got %b want 101", {halted, op_ready, done});
        end
        op       = 4'd1;
        op_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (halted !== 1'b1 || op_ready !== 1'b0 || strb !== IDLE_V) begin
                errors++;
                $display("FAIL hlt_hold%0d: got h=%b r=%b %b want 1 0 %b",
                         k, halted, op_ready, strb, IDLE_V);
            end
        end
        op_valid = 1'b0;
        checks++;
        if (icount !== 8'd1) begin
            errors++;
            $display("FAIL hlt_icount: got %0d want 1", icount);
        end
    endtask

    task automatic test_flags;
        do_reset();
        alu_cf = 1'b1;
        send(4'd3);
        tick();
        tick();
        checks++;
        if (Eu !== 1'b1) begin
            errors++;
            $display("FAIL flags_add_exec: got Eu=%b want 1", Eu);
        end
        tick();
`ifdef SEQ_FLAGS_EN
        checks++;
        if (flag_c !== 1'b1) begin
            errors++;
            $display("FAIL flags_c_set: got %b want 1", flag_c);
        end
        alu_cf = 1'b0;
        send(4'd8);
        checks++;
        if (strb !== 9'b000011100) begin
            errors++;
            $display("FAIL subc_setup: got %b want 000011100", strb);
        end
        tick();
        tick();
        checks++;
        if (strb !== 9'b000101101) begin
            errors++;
            $display("FAIL subc_exec: got %b want 000101101", strb);
        end
        tick();
        checks++;
        if (flag_c !== 1'b0) begin
            errors++;
            $display("FAIL flags_c_clr: got %b want 0", flag_c);
        end
        send(4'd8);
        checks++;
        if (strb !== 9'b000011001 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL subc_nop: got %b ill=%b want 000011001 0", strb, illegal);
        end
        tick();
`else
        checks++;
        if (flag_c !== 1'b0 || flag_z !== 1'b0) begin
            errors++;
            $display("FAIL flags_off: got %b%b want 00", flag_c, flag_z);
        end
        alu_cf = 1'b0;
`endif
    endtask

    task automatic test_wrap;
        do_reset();
        for (int k = 0; k < 255; k++) begin
            send(4'd0);
            tick();
        end
        checks++;
        if (icount !== 8'd255) begin
            errors++;
            $display("FAIL wrap_255: got %0d want 255", icount);
        end
        send(4'd0);
        tick();
        checks++;
        if (icount !== 8'd0) begin
            errors++;
            $display("FAIL wrap_0: got %0d want 0", icount);
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_sub_settle();
        test_stream();
        test_illegal();
        test_halt();
        test_flags();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
